// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to the instruction
// cache under a credit limit, and queues in-order responses for decode.
module instruction_fetch #(
    parameter logic [27:0] RESET_ADDR = 28'h0000000,
    parameter int          DEPTH      = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [27:0] jmp_addr_i,
    input  logic        jmp_valid_i,
    input  logic        halt_i,
    output logic [27:0] ic_req_addr_o,
    output logic        ic_req_valid_o,
    input  logic        ic_req_ready_i,
    input  logic [27:0] ic_resp_addr_i,
    input  logic [31:0] ic_resp_data_i,
    input  logic        ic_resp_valid_i,
    output logic        ic_resp_ready_o,
    output logic [27:0] if_pc_o,
    output logic [31:0] if_ir_o,
    output logic        if_valid_o,
    input  logic        if_ready_i
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [27:0]   pc_r;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] drop_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [27:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic [CW:0] occupancy;
    logic        req_fire;
    logic        resp_fire;
    logic        pop;
    logic        keep;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both in-flight requests (stale ones too) and queued results,
    // so every kept response is guaranteed a FIFO slot.
    assign occupancy      = {1'b0, inflight_r} + {1'b0, count_r};
    assign ic_req_addr_o  = pc_r;
    assign ic_req_valid_o = !reset_i && !halt_i && !jmp_valid_i
                            && (occupancy < (CW+1)'(DEPTH));
    assign ic_resp_ready_o = !reset_i;

    assign if_valid_o = (count_r != '0) && !jmp_valid_i;
    assign if_pc_o    = addr_q[rd_ptr_r];
    assign if_ir_o    = data_q[rd_ptr_r];

    assign req_fire  = ic_req_valid_o && ic_req_ready_i;
    assign resp_fire = ic_resp_valid_i;
    assign pop       = if_valid_o && if_ready_i;
    assign keep      = resp_fire && !jmp_valid_i && (drop_r == '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_r       <= RESET_ADDR;
            inflight_r <= '0;
            drop_r     <= '0;
            count_r    <= '0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            inflight_r <= inflight_r + CW'(req_fire) - CW'(resp_fire);
            if (jmp_valid_i) begin
                // Everything still outstanding after this cycle belongs to the old path.
                pc_r     <= jmp_addr_i;
                drop_r   <= inflight_r - CW'(resp_fire);
                count_r  <= '0;
                rd_ptr_r <= '0;
                wr_ptr_r <= '0;
            end else begin
                if (req_fire)
                    pc_r <= pc_r + 28'd1;
                if (resp_fire && (drop_r != '0))
                    drop_r <= drop_r - CW'(1);
                if (keep) begin
                    addr_q[wr_ptr_r] <= ic_resp_addr_i;
                    data_q[wr_ptr_r] <= ic_resp_data_i;
                    wr_ptr_r         <= ptr_inc(wr_ptr_r);
                end
                if (pop)
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                if (keep && !pop)
                    count_r <= count_r + CW'(1);
                else if (!keep && pop)
                    count_r <= count_r - CW'(1);
            end
        end
    end

`ifndef SYNTHESIS
    // Address the next kept response must carry: live requests run sequentially
    // from the most recent redirect target.
    logic [27:0] exp_addr_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            exp_addr_r <= RESET_ADDR;
        else if (jmp_valid_i)
            exp_addr_r <= jmp_addr_i;
        else if (keep)
            exp_addr_r <= exp_addr_r + 28'd1;
    end

    a_resp_order: assert property (@(posedge clk_i) disable iff (reset_i)
        keep |-> (ic_resp_addr_i == exp_addr_r));

    a_resp_credit: assert property (@(posedge clk_i) disable iff (reset_i)
        ic_resp_valid_i |-> (inflight_r != '0));
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, then randomized traffic against a
// transaction-level model (epoch-tagged cache queue plus expected decode queue).
module tb_instruction_fetch;
    localparam int DEPTH = 3;
    localparam logic [27:0] RST_A = 28'h0000000;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [27:0] jmp_addr_i = '0;
    logic        jmp_valid_i = 1'b0;
    logic        halt_i = 1'b0;
    logic [27:0] ic_req_addr_o;
    logic        ic_req_valid_o;
    logic        ic_req_ready_i = 1'b0;
    logic [27:0] ic_resp_addr_i = '0;
    logic [31:0] ic_resp_data_i = '0;
    logic        ic_resp_valid_i = 1'b0;
    logic        ic_resp_ready_o;
    logic [27:0] if_pc_o;
    logic [31:0] if_ir_o;
    logic        if_valid_o;
    logic        if_ready_i = 1'b0;

    instruction_fetch #(.RESET_ADDR(RST_A), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .jmp_addr_i(jmp_addr_i), .jmp_valid_i(jmp_valid_i), .halt_i(halt_i),
        .ic_req_addr_o(ic_req_addr_o), .ic_req_valid_o(ic_req_valid_o),
        .ic_req_ready_i(ic_req_ready_i),
        .ic_resp_addr_i(ic_resp_addr_i), .ic_resp_data_i(ic_resp_data_i),
        .ic_resp_valid_i(ic_resp_valid_i), .ic_resp_ready_o(ic_resp_ready_o),
        .if_pc_o(if_pc_o), .if_ir_o(if_ir_o), .if_valid_o(if_valid_o),
        .if_ready_i(if_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] idata(input logic [27:0] a);
        return {a[3:0] ^ 4'h5, a} ^ 32'h00A5_5A00;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic jmp; logic [27:0] ja; logic halt; logic rqr;
        logic rspv; logic [27:0] rspa; logic ifr;
        logic e_rqv; logic [27:0] e_rqa; logic e_ifv; logic [27:0] e_pc;
    } vec_t;

    function automatic vec_t v(logic jmp, logic [27:0] ja, logic halt, logic rqr,
                               logic rspv, logic [27:0] rspa, logic ifr,
                               logic e_rqv, logic [27:0] e_rqa, logic e_ifv, logic [27:0] e_pc);
        vec_t r;
        r.jmp = jmp; r.ja = ja; r.halt = halt; r.rqr = rqr; r.rspv = rspv; r.rspa = rspa;
        r.ifr = ifr; r.e_rqv = e_rqv; r.e_rqa = e_rqa; r.e_ifv = e_ifv; r.e_pc = e_pc;
        return r;
    endfunction

    vec_t tbl[28];

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1; jmp_valid_i = 1'b0; halt_i = 1'b0; ic_req_ready_i = 1'b0;
        ic_resp_valid_i = 1'b0; if_ready_i = 1'b0;
        #1;
        check("rst_req_valid", 32'(ic_req_valid_o), 0);
        check("rst_resp_ready", 32'(ic_resp_ready_o), 0);
        check("rst_if_valid", 32'(if_valid_o), 0);
        check("rst_req_addr", 32'(ic_req_addr_o), 32'(RST_A));
        check("rst_if_pc", 32'(if_pc_o), 0);
        check("rst_if_ir", if_ir_o, 0);
        repeat (2) @(posedge clk_i);
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [27:0] addr; int epoch; int due; } pend_t;
    typedef struct { logic [27:0] pc; logic [31:0] ir; } ent_t;

    pend_t pend[$];
    ent_t  dq[$];
    int    inflight, epoch, cyc, lat_min, lat_max;
    int    p_jmp, p_halt, p_ifr, p_rqr, win_lo, seen;
    logic [27:0] next_pc;

    task automatic model_clear();
        pend.delete(); dq.delete();
        inflight = 0; epoch = 0; cyc = 0; seen = 0; next_pc = RST_A;
    endtask

    task automatic cycle_model();
        bit jmp, halt, ifr, rqr, rspv, erv, eiv;
        logic [27:0] ja;
        pend_t r;
        @(negedge clk_i);
        jmp  = ($urandom_range(99) < p_jmp);
        ja   = ($urandom_range(3) == 0) ? 28'hFFFFFFD + 28'($urandom_range(2)) : 28'($urandom);
        halt = ($urandom_range(99) < p_halt);
        ifr  = ($urandom_range(99) < p_ifr);
        rqr  = ($urandom_range(99) < p_rqr);
        rspv = (pend.size() > 0) && (pend[0].due <= cyc);
        reset_i = 1'b0; jmp_valid_i = jmp; jmp_addr_i = ja; halt_i = halt;
        if_ready_i = ifr; ic_req_ready_i = rqr; ic_resp_valid_i = rspv;
        ic_resp_addr_i = rspv ? pend[0].addr : 28'($urandom);
        ic_resp_data_i = rspv ? idata(pend[0].addr) : $urandom;
        #1;
        erv = !halt && !jmp && (inflight + dq.size() < DEPTH);
        eiv = (dq.size() != 0) && !jmp;
        check("m_req_valid", 32'(ic_req_valid_o), 32'(erv));
        if (erv) check("m_req_addr", 32'(ic_req_addr_o), 32'(next_pc));
        check("m_if_valid", 32'(if_valid_o), 32'(eiv));
        if (eiv) begin
            check("m_if_pc", 32'(if_pc_o), 32'(dq[0].pc));
            check("m_if_ir", if_ir_o, dq[0].ir);
        end
        check("m_resp_ready", 32'(ic_resp_ready_o), 1);
        if (cyc >= win_lo && if_valid_o) seen++;
        if (eiv && ifr) void'(dq.pop_front());
        if (rspv) begin
            r = pend.pop_front();
            inflight--;
            if (!jmp && r.epoch == epoch) dq.push_back('{r.addr, idata(r.addr)});
        end
        if (jmp) begin
            dq.delete(); epoch++; next_pc = ja;
        end else if (erv && rqr) begin
            pend.push_back('{next_pc, epoch, cyc + $urandom_range(lat_max, lat_min)});
            inflight++; next_pc = next_pc + 28'd1;
        end
        cyc++;
    endtask

    initial begin
        //            jmp ja           hlt rqr rv rspa         ifr  erv erqa         eiv epc
        tbl[0]  = v(0, 0,           0, 1, 0, 0,           0,   1, 0,           0, 0);
        tbl[1]  = v(0, 0,           0, 1, 0, 0,           0,   1, 1,           0, 0);
        tbl[2]  = v(0, 0,           0, 1, 0, 0,           0,   1, 2,           0, 0);
        tbl[3]  = v(0, 0,           0, 1, 1, 0,           0,   0, 0,           0, 0);
        tbl[4]  = v(0, 0,           0, 1, 1, 1,           0,   0, 0,           1, 0);
        tbl[5]  = v(0, 0,           0, 1, 1, 2,           0,   0, 0,           1, 0);
        tbl[6]  = v(0, 0,           0, 1, 0, 0,           0,   0, 0,           1, 0);
        tbl[7]  = v(0, 0,           0, 1, 0, 0,           1,   0, 0,           1, 0);
        tbl[8]  = v(0, 0,           0, 1, 0, 0,           1,   1, 3,           1, 1);
        tbl[9]  = v(0, 0,           0, 1, 0, 0,           1,   1, 4,           1, 2);
        tbl[10] = v(0, 0,           0, 0, 0, 0,           1,   1, 5,           0, 0);
        tbl[11] = v(1, 28'h100,     0, 1, 1, 3,           1,   0, 0,           0, 0);
        tbl[12] = v(0, 0,           0, 1, 1, 4,           1,   1, 28'h100,     0, 0);
        tbl[13] = v(0, 0,           0, 0, 1, 28'h100,     0,   1, 28'h101,     0, 0);
        tbl[14] = v(0, 0,           0, 0, 0, 0,           0,   1, 28'h101,     1, 28'h100);
        tbl[15] = v(0, 0,           1, 1, 0, 0,           1,   0, 0,           1, 28'h100);
        tbl[16] = v(0, 0,           1, 1, 0, 0,           1,   0, 0,           0, 0);
        tbl[17] = v(0, 0,           0, 1, 0, 0,           1,   1, 28'h101,     0, 0);
        tbl[18] = v(0, 0,           0, 0, 1, 28'h101,     0,   1, 28'h102,     0, 0);
        tbl[19] = v(1, 28'hFFFFFFE, 0, 1, 0, 0,           1,   0, 0,           0, 0);
        tbl[20] = v(0, 0,           0, 1, 0, 0,           1,   1, 28'hFFFFFFE, 0, 0);
        tbl[21] = v(0, 0,           0, 1, 0, 0,           1,   1, 28'hFFFFFFF, 0, 0);
        tbl[22] = v(0, 0,           0, 1, 0, 0,           1,   1, 0,           0, 0);
        tbl[23] = v(0, 0,           0, 1, 1, 28'hFFFFFFE, 1,   0, 0,           0, 0);
        tbl[24] = v(0, 0,           0, 1, 1, 28'hFFFFFFF, 1,   0, 0,           1, 28'hFFFFFFE);
        tbl[25] = v(0, 0,           0, 0, 1, 0,           1,   1, 1,           1, 28'hFFFFFFF);
        tbl[26] = v(0, 0,           0, 0, 0, 0,           1,   1, 1,           1, 0);
        tbl[27] = v(0, 0,           0, 0, 0, 0,           1,   1, 1,           0, 0);

        do_reset();
        for (int i = 0; i < 28; i++) begin
            @(negedge clk_i);
            reset_i = 1'b0;
            jmp_valid_i = tbl[i].jmp; jmp_addr_i = tbl[i].ja; halt_i = tbl[i].halt;
            ic_req_ready_i = tbl[i].rqr; ic_resp_valid_i = tbl[i].rspv;
            ic_resp_addr_i = tbl[i].rspa; ic_resp_data_i = idata(tbl[i].rspa);
            if_ready_i = tbl[i].ifr;
            #1;
            check($sformatf("v%0d_req_valid", i), 32'(ic_req_valid_o), 32'(tbl[i].e_rqv));
            if (tbl[i].e_rqv)
                check($sformatf("v%0d_req_addr", i), 32'(ic_req_addr_o), 32'(tbl[i].e_rqa));
            check($sformatf("v%0d_if_valid", i), 32'(if_valid_o), 32'(tbl[i].e_ifv));
            if (tbl[i].e_ifv) begin
                check($sformatf("v%0d_if_pc", i), 32'(if_pc_o), 32'(tbl[i].e_pc));
                check($sformatf("v%0d_if_ir", i), if_ir_o, idata(tbl[i].e_pc));
            end
            check($sformatf("v%0d_resp_ready", i), 32'(ic_resp_ready_o), 1);
        end

        // Sustained one-per-cycle delivery with a single-cycle cache.
        do_reset();
        model_clear();
        lat_min = 1; lat_max = 1; p_jmp = 0; p_halt = 0; p_ifr = 100; p_rqr = 100; win_lo = 10;
        repeat (50) cycle_model();
        check("throughput", seen, 40);

        // Three-cycle cache, decode always ready: sequential PCs from reset.
        do_reset();
        model_clear();
        lat_min = 3; lat_max = 3; win_lo = 1 << 30;
        repeat (60) cycle_model();

        // Randomized redirects, halts, back-pressure and latency, with a mid-run reset.
        do_reset();
        model_clear();
        lat_min = 1; lat_max = 5; p_jmp = 5; p_halt = 15; p_ifr = 70; p_rqr = 75;
        repeat (1500) cycle_model();
        do_reset();
        model_clear();
        p_jmp = 12; p_halt = 30; p_ifr = 50; p_rqr = 60;
        repeat (1500) cycle_model();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
